// File: rtl/tag_arb_pkg.sv
// rtl/tag_arb_pkg.sv - shared widths, sync FSM states and line record for tag_arbiter_sa
package tag_arb_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ADDR_WID   = 32;
    localparam int DEF_OFFSET_WID = 4;
    localparam int DEF_SET_NUM    = 4;
    localparam int DEF_WAY_NUM    = 4;
    localparam int DEF_M_WIDTH    = 2;
    localparam int DEF_SET_WID    = clog2_min1(DEF_SET_NUM);
    localparam int DEF_WAY_WID    = clog2_min1(DEF_WAY_NUM);
    localparam int DEF_TAG_WID    = DEF_ADDR_WID - DEF_SET_WID - DEF_OFFSET_WID;

    typedef enum logic [1:0] {
        SYNC_IDLE,
        SYNC_SCAN,
        SYNC_WB,
        SYNC_DONE
    } sync_state_t;

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [DEF_M_WIDTH-1:0] rrpv;
        logic [DEF_TAG_WID-1:0] tag;
    } line_t;

endpackage

// File: rtl/rrip_victim_sel.sv
// rtl/rrip_victim_sel.sv - SRRIP victim pick and refill aging delta for one set
module rrip_victim_sel #(
    parameter int WAY_NUM = 4,
    parameter int M_WIDTH = 2,
    parameter int WAY_WID = 2
) (
    input  logic [WAY_NUM-1:0]              valid,
    input  logic [WAY_NUM-1:0][M_WIDTH-1:0] rrpv,
    output logic [WAY_WID-1:0]              victim_way,
    output logic [M_WIDTH-1:0]              age_delta
);

    localparam logic [M_WIDTH-1:0] RRPV_MAX = '1;

    logic               found_inv;
    logic [M_WIDTH-1:0] best;

    always_comb begin
        victim_way = '0;
        found_inv  = 1'b0;
        best       = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                victim_way = WAY_WID'(i);
                found_inv  = 1'b1;
            end
        end
        // >= lets a later (higher) way win an RRPV tie
        if (!found_inv) begin
            for (int i = 0; i < WAY_NUM; i++) begin
                if (rrpv[i] >= best) begin
                    best       = rrpv[i];
                    victim_way = WAY_WID'(i);
                end
            end
        end
        // Filling an empty way leaves the ages of the others untouched
        age_delta = found_inv ? '0 : (RRPV_MAX - best);
    end

endmodule

// File: rtl/tag_arbiter_sa.sv
// rtl/tag_arbiter_sa.sv - set-associative tag manager with SRRIP victim and dirty sync engine (TAG_ARB_PERF_CNT_EN adds hit/miss counters)
module tag_arbiter_sa
    import tag_arb_pkg::*;
#(
    parameter  int ADDR_WID   = DEF_ADDR_WID,
    parameter  int OFFSET_WID = DEF_OFFSET_WID,
    parameter  int SET_NUM    = DEF_SET_NUM,
    parameter  int WAY_NUM    = DEF_WAY_NUM,
    parameter  int M_WIDTH    = DEF_M_WIDTH,
    localparam int SET_WID    = clog2_min1(SET_NUM),
    localparam int WAY_WID    = clog2_min1(WAY_NUM),
    localparam int TAG_WID    = ADDR_WID - SET_WID - OFFSET_WID
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                access_valid,
    input  logic                access_wr,
    input  logic [ADDR_WID-1:0] access_addr,
    output logic                access_ready,
    output logic                hit,
    output logic                miss,
    output logic [WAY_WID-1:0]  hit_way,
    output logic [WAY_WID-1:0]  victim_way,
    output logic                victim_dirty,
    output logic [TAG_WID-1:0]  victim_tag,
    input  logic                refill_valid,
    input  logic [ADDR_WID-1:0] refill_addr,
    input  logic                valid_clear,
    input  logic                sync_req,
    output logic                sync_busy,
    output logic                sync_done,
    output logic                wb_req,
    output logic [SET_WID-1:0]  wb_set,
    output logic [WAY_WID-1:0]  wb_way,
    output logic [TAG_WID-1:0]  wb_tag,
    input  logic                wb_ack,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
);

    localparam int LINES   = SET_NUM * WAY_NUM;
    localparam int IDX_WID = clog2_min1(LINES);
    localparam logic [M_WIDTH-1:0] RRPV_MAX = '1;
    localparam logic [M_WIDTH-1:0] RRPV_INS = M_WIDTH'(RRPV_MAX - 1'b1);

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [M_WIDTH-1:0] rrpv;
        logic [TAG_WID-1:0] tag;
    } line_s;

    line_s lines [SET_NUM][WAY_NUM];

    sync_state_t          state, state_nxt;
    logic [IDX_WID-1:0]   idx, idx_nxt;

    logic [SET_WID-1:0]              acc_set;
    logic [TAG_WID-1:0]              acc_tag, ref_tag;
    logic                            hit_any;
    logic [WAY_NUM-1:0]              set_valid;
    logic [WAY_NUM-1:0][M_WIDTH-1:0] set_rrpv;
    logic [M_WIDTH-1:0]              age_delta;
    logic [M_WIDTH:0]                age_sum [WAY_NUM];
    logic [M_WIDTH-1:0]              aged    [WAY_NUM];
    logic                            refill_en, clear_en, wb_done, scan_hit, idx_last;
    logic                            unused_addr_bits;

    assign acc_set = access_addr[OFFSET_WID +: SET_WID] & SET_WID'(SET_NUM - 1);
    assign acc_tag = access_addr[ADDR_WID-1 -: TAG_WID];
    assign ref_tag = refill_addr[ADDR_WID-1 -: TAG_WID];
    assign unused_addr_bits = ^{access_addr[OFFSET_WID-1:0], refill_addr[OFFSET_WID+SET_WID-1:0]};

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            set_valid[w] = lines[acc_set][w].valid;
            set_rrpv[w]  = lines[acc_set][w].rrpv;
            if (lines[acc_set][w].valid && lines[acc_set][w].tag == acc_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_WID'(w);
            end
        end
    end

    rrip_victim_sel #(
        .WAY_NUM (WAY_NUM),
        .M_WIDTH (M_WIDTH),
        .WAY_WID (WAY_WID)
    ) u_victim_sel (
        .valid      (set_valid),
        .rrpv       (set_rrpv),
        .victim_way (victim_way),
        .age_delta  (age_delta)
    );

    always_comb begin
        for (int w = 0; w < WAY_NUM; w++) begin
            age_sum[w] = {1'b0, set_rrpv[w]} + {1'b0, age_delta};
            aged[w]    = age_sum[w][M_WIDTH] ? RRPV_MAX : age_sum[w][M_WIDTH-1:0];
        end
    end

    assign access_ready = (state == SYNC_IDLE);
    assign sync_busy    = (state != SYNC_IDLE);
    assign sync_done    = (state == SYNC_DONE);
    assign wb_req       = (state == SYNC_WB);
    assign hit          = access_valid & access_ready & hit_any;
    assign miss         = access_valid & access_ready & ~hit_any;
    assign victim_dirty = lines[acc_set][victim_way].valid & lines[acc_set][victim_way].dirty;
    assign victim_tag   = lines[acc_set][victim_way].tag;

    assign wb_set   = SET_WID'(idx / WAY_NUM);
    assign wb_way   = WAY_WID'(idx % WAY_NUM);
    assign wb_tag   = lines[wb_set][wb_way].tag;
    assign scan_hit = lines[wb_set][wb_way].valid & lines[wb_set][wb_way].dirty;
    assign idx_last = (idx == IDX_WID'(LINES - 1));

    // A refill is only a commit for an access the arbiter accepted, so it waits out a sync
    assign refill_en = refill_valid & access_ready;
    assign clear_en  = valid_clear & ~sync_busy;
    assign wb_done   = wb_req & wb_ack;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            SYNC_IDLE: if (sync_req) begin
                state_nxt = SYNC_SCAN;
                idx_nxt   = '0;
            end
            SYNC_SCAN: begin
                if (scan_hit)      state_nxt = SYNC_WB;
                else if (idx_last) state_nxt = SYNC_DONE;
                else               idx_nxt   = idx + IDX_WID'(1);
            end
            SYNC_WB: if (wb_ack) begin
                if (idx_last) state_nxt = SYNC_DONE;
                else begin
                    state_nxt = SYNC_SCAN;
                    idx_nxt   = idx + IDX_WID'(1);
                end
            end
            default: state_nxt = SYNC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SET_NUM; s++)
                for (int w = 0; w < WAY_NUM; w++)
                    lines[s][w] <= '0;
        end else if (clear_en) begin
            for (int s = 0; s < SET_NUM; s++)
                for (int w = 0; w < WAY_NUM; w++) begin
                    lines[s][w].valid <= 1'b0;
                    lines[s][w].dirty <= 1'b0;
                end
        end else begin
            for (int w = 0; w < WAY_NUM; w++) begin
                if (refill_en && WAY_WID'(w) == victim_way) begin
                    lines[acc_set][w] <= '{1'b1, 1'b0, RRPV_INS, ref_tag};
                end else begin
                    if (refill_en && lines[acc_set][w].valid)
                        lines[acc_set][w].rrpv <= aged[w];
                    // A hit on a non-victim way keeps its promotion over the refill aging
                    if (hit && WAY_WID'(w) == hit_way) begin
                        lines[acc_set][w].rrpv <= '0;
                        if (access_wr)
                            lines[acc_set][w].dirty <= 1'b1;
                    end
                end
            end
            if (wb_done)
                lines[wb_set][wb_way].dirty <= 1'b0;
        end
    end

`ifdef TAG_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
